// File: rtl/kplic_gateway.sv
// kplic_gateway: per-source interrupt gateway between raw interrupt lines and the KPLIC core.
// Latency: a raw line sampled high at edge N raises valid_int_req after edge N+2
//   (two synchronizer flops, then a registered issue pulse).
// Backpressure: a source issues only once from IDLE. It then waits for a claim and a complete.
//   Edges that arrive while it waits are counted up to the saturation limit.
//
// Ports:
//   kplic_clk, kplic_rstn    clock; asynchronous active-low reset
//   ext_int_src              raw interrupt lines, asynchronous to kplic_clk
//   int_trigger_type         per source: 1 = rising edge, 0 = level high
//   int_enable               per source: gates new issues only
//   int_claim / claim_id     one-cycle claim strobe and the claimed ID
//   int_complete/complete_id one-cycle completion strobe and the completed ID
//   valid_int_req            one-cycle request pulse per issue
//   int_in_service           source is in SERVICE
//   int_wait_claim           source is in WAIT
module kplic_gateway #(
  parameter int INT_NUM        = 32,
  parameter int INT_WIDTH      = 5,
  parameter int EDGE_CNT_WIDTH = 2
) (
  input  logic                 kplic_clk,
  input  logic                 kplic_rstn,
  input  logic [INT_NUM-1:0]   ext_int_src,
  input  logic [INT_NUM-1:0]   int_trigger_type,
  input  logic [INT_NUM-1:0]   int_enable,
  input  logic                 int_claim,
  input  logic [INT_WIDTH-1:0] claim_id,
  input  logic                 int_complete,
  input  logic [INT_WIDTH-1:0] complete_id,
  output logic [INT_NUM-1:0]   valid_int_req,
  output logic [INT_NUM-1:0]   int_in_service,
  output logic [INT_NUM-1:0]   int_wait_claim
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_SERVICE = 2'd2
  } state_e;

  localparam logic [EDGE_CNT_WIDTH-1:0] CNT_MAX = '1;

  state_e                    state_q [INT_NUM];
  state_e                    state_d [INT_NUM];
  logic [EDGE_CNT_WIDTH-1:0] cnt_q   [INT_NUM];
  logic [EDGE_CNT_WIDTH-1:0] cnt_d   [INT_NUM];

  logic [INT_NUM-1:0] sync_meta_q;  // first synchronizer flop
  logic [INT_NUM-1:0] sync_lvl_q;   // second synchronizer flop
  logic [INT_NUM-1:0] sync_prev_q;  // sync_lvl delayed one cycle
  logic [INT_NUM-1:0] trig_prev_q;  // last trigger type, used to spot a change
  logic [INT_NUM-1:0] vld_q;
  logic [INT_NUM-1:0] vld_d;
  logic [INT_NUM-1:0] edge_det;

  always_comb begin
    edge_det = sync_lvl_q & ~sync_prev_q;
    vld_d    = '0;
    for (int i = 0; i < INT_NUM; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];

      // A pending edge source is one with a fresh edge or a stored edge.
      if (state_q[i] == ST_IDLE && int_enable[i]) begin
        vld_d[i] = int_trigger_type[i] ? (edge_det[i] || (cnt_q[i] != '0)) : sync_lvl_q[i];
      end

      // Only one state can match for a given source. A claim and a complete in the
      // same cycle therefore resolve independently.
      case (state_q[i])
        ST_IDLE:    if (vld_d[i]) state_d[i] = ST_WAIT;
        ST_WAIT:    if (int_claim && claim_id == INT_WIDTH'(i)) state_d[i] = ST_SERVICE;
        ST_SERVICE: if (int_complete && complete_id == INT_WIDTH'(i)) state_d[i] = ST_IDLE;
        default:    state_d[i] = ST_IDLE;
      endcase

      // Edge count rule: count + edge - issue, saturating at both ends.
      // An edge that coincides with an issue leaves the count as it is.
      // A trigger-type change clears the count. Level sources always hold 0.
      if (int_trigger_type[i] != trig_prev_q[i] || !int_trigger_type[i]) begin
        cnt_d[i] = '0;
      end else if (edge_det[i] && !vld_d[i]) begin
        if (cnt_q[i] != CNT_MAX) cnt_d[i] = cnt_q[i] + 1'b1;
      end else if (!edge_det[i] && vld_d[i]) begin
        // An issue without a fresh edge only happens when the count is non-zero.
        cnt_d[i] = cnt_q[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge kplic_clk or negedge kplic_rstn) begin
    if (!kplic_rstn) begin
      sync_meta_q <= '0;
      sync_lvl_q  <= '0;
      sync_prev_q <= '0;
      trig_prev_q <= '0;
      vld_q       <= '0;
      for (int i = 0; i < INT_NUM; i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      sync_meta_q <= ext_int_src;
      sync_lvl_q  <= sync_meta_q;
      sync_prev_q <= sync_lvl_q;
      trig_prev_q <= int_trigger_type;
      vld_q       <= vld_d;
      for (int i = 0; i < INT_NUM; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  always_comb begin
    int_in_service = '0;
    int_wait_claim = '0;
    for (int i = 0; i < INT_NUM; i++) begin
      int_in_service[i] = (state_q[i] == ST_SERVICE);
      int_wait_claim[i] = (state_q[i] == ST_WAIT);
    end
  end

  assign valid_int_req = vld_q;

endmodule

// File: tb/tb_kplic_gateway.sv
// tb_kplic_gateway: directed scenarios plus randomized traffic for kplic_gateway.
// The randomized traffic is compared against a reference model of the gateway.
// Latency: the model predicts outputs one clock edge at a time.
// Backpressure: not applicable; the bench drives the strobes freely.
module tb_kplic_gateway;

  logic        clk;
  logic        rstn;
  logic [31:0] src;
  logic [31:0] ttype;
  logic [31:0] en;
  logic        claim;
  logic [4:0]  cid;
  logic        comp;
  logic [4:0]  coid;
  logic [31:0] vld;
  logic [31:0] srv;
  logic [31:0] wt;

  int tests;
  int fails;

  kplic_gateway #(.INT_NUM(32), .INT_WIDTH(5), .EDGE_CNT_WIDTH(2)) dut (
    .kplic_clk        (clk),
    .kplic_rstn       (rstn),
    .ext_int_src      (src),
    .int_trigger_type (ttype),
    .int_enable       (en),
    .int_claim        (claim),
    .claim_id         (cid),
    .int_complete     (comp),
    .complete_id      (coid),
    .valid_int_req    (vld),
    .int_in_service   (srv),
    .int_wait_claim   (wt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // Reference model. The raw line shifts through a three-deep history:
  // h2 is the synchronized level and h3 is the level one cycle earlier.
  // Each source holds a state (0 idle, 1 wait, 2 service) and an integer edge count.
  bit [31:0] h1, h2, h3, m_vld, m_ptype;
  int        m_st  [32];
  int        m_cnt [32];

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      h1 = 0; h2 = 0; h3 = 0; m_vld = 0; m_ptype = 0;
      for (int i = 0; i < 32; i++) begin
        m_st[i]  = 0;
        m_cnt[i] = 0;
      end
    end else begin
      bit [31:0] nv;
      nv = 0;
      for (int i = 0; i < 32; i++) begin
        int e;
        int pend;
        int iss;
        e    = (h2[i] && !h3[i]) ? 1 : 0;
        pend = ttype[i] ? ((e == 1 || m_cnt[i] > 0) ? 1 : 0) : int'(h2[i]);
        iss  = (m_st[i] == 0 && en[i] && pend == 1) ? 1 : 0;
        nv[i] = (iss == 1);
        if (iss == 1) m_st[i] = 1;
        else if (m_st[i] == 1 && claim && int'(cid) == i) m_st[i] = 2;
        else if (m_st[i] == 2 && comp && int'(coid) == i) m_st[i] = 0;
        if (ttype[i] != m_ptype[i] || !ttype[i]) m_cnt[i] = 0;
        else begin
          m_cnt[i] = m_cnt[i] + e - iss;
          if (m_cnt[i] > 3) m_cnt[i] = 3;
          if (m_cnt[i] < 0) m_cnt[i] = 0;
        end
      end
      m_vld = nv;
      h3 = h2; h2 = h1; h1 = src; m_ptype = ttype;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    src = 0; ttype = 0; en = 0; claim = 0; cid = 0; comp = 0; coid = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rstn = 1'b0;
    tick(); tick();
    rstn = 1'b1;
    tick();
  endtask

  task automatic strobe_claim(input int id);
    claim = 1'b1; cid = 5'(id); tick(); claim = 1'b0;
  endtask

  task automatic strobe_complete(input int id);
    comp = 1'b1; coid = 5'(id); tick(); comp = 1'b0;
  endtask

  task automatic pulse(input logic [31:0] mask);
    src = src | mask; tick(); tick();
    src = src & ~mask; tick(); tick();
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if (vld !== 32'h0 || srv !== 32'h0 || wt !== 32'h0) begin
      fails++;
      $display("[TB] FAIL reset_state: got vld=%h srv=%h wt=%h, required all 0", vld, srv, wt);
    end
  endtask

  task automatic test_level();
    logic [31:0] seen [4];
    do_reset();
    en = 32'h8;
    src[3] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      seen[k] = vld;
    end
    tests++;
    if (seen[0] !== 0 || seen[1] !== 0 || seen[2] !== 32'h8 || seen[3] !== 0) begin
      fails++;
      $display("[TB] FAIL level_latency: got %h %h %h %h, required 0 0 8 0",
               seen[0], seen[1], seen[2], seen[3]);
    end
    tests++;
    if (wt !== 32'h8) begin
      fails++;
      $display("[TB] FAIL level_wait: got wt=%h, required 8", wt);
    end
    strobe_claim(3);
    tests++;
    if (srv !== 32'h8 || wt !== 32'h0) begin
      fails++;
      $display("[TB] FAIL level_claim: got srv=%h wt=%h, required srv=8 wt=0", srv, wt);
    end
    strobe_complete(3);
    tests++;
    if (srv !== 0 || wt !== 0 || vld !== 0) begin
      fails++;
      $display("[TB] FAIL level_gap: got srv=%h wt=%h vld=%h, required all 0", srv, wt, vld);
    end
    tick();
    tests++;
    if (vld !== 32'h8 || wt !== 32'h8) begin
      fails++;
      $display("[TB] FAIL level_reissue: got vld=%h wt=%h, required 8 8", vld, wt);
    end
    strobe_claim(3);
    src[3] = 1'b0;
    tick(); tick(); tick();
    strobe_complete(3);
    tick(); tick();
    tests++;
    if (vld !== 0 || wt !== 0 || srv !== 0) begin
      fails++;
      $display("[TB] FAIL level_release: got vld=%h wt=%h srv=%h, required all 0", vld, wt, srv);
    end
  endtask

  task automatic test_edge_saturate();
    bit got;
    do_reset();
    ttype = 32'h80; en = 32'h80;
    tick();
    src[7] = 1'b1;
    got = 0;
    for (int k = 0; k < 10 && !got; k++) begin
      tick();
      if (vld[7]) got = 1;
    end
    tests++;
    if (!got) begin
      fails++;
      $display("[TB] FAIL edge_first_issue: got no request in 10 cycles, required vld[7]");
    end
    src[7] = 1'b0;
    tick(); tick();
    strobe_claim(7);
    for (int p = 0; p < 5; p++) pulse(32'h80);
    tick(); tick();
    for (int r = 0; r < 4; r++) begin
      strobe_complete(7);
      tick();
      tests++;
      if (r < 3 && (vld[7] !== 1'b1 || wt[7] !== 1'b1)) begin
        fails++;
        $display("[TB] FAIL edge_round%0d: got vld7=%b wt7=%b, required 1 1", r, vld[7], wt[7]);
      end else if (r == 3 && (vld !== 0 || wt !== 0 || srv !== 0)) begin
        fails++;
        $display("[TB] FAIL edge_drained: got vld=%h wt=%h srv=%h, required all 0", vld, wt, srv);
      end
      if (r < 3) strobe_claim(7);
    end
  endtask

  task automatic test_enable();
    bit bad;
    do_reset();
    ttype = 32'h1; en = 32'h0;
    tick();
    pulse(32'h1);
    tick();
    tests++;
    if (vld !== 0 || wt !== 0) begin
      fails++;
      $display("[TB] FAIL edge_disabled: got vld=%h wt=%h, required 0 0", vld, wt);
    end
    en[0] = 1'b1;
    tick();
    tests++;
    if (vld !== 32'h1) begin
      fails++;
      $display("[TB] FAIL edge_latched_issue: got vld=%h, required 1", vld);
    end
    strobe_claim(0);
    strobe_complete(0);
    tick(); tick();
    tests++;
    if (vld !== 0 || wt !== 0) begin
      fails++;
      $display("[TB] FAIL edge_single_latch: got vld=%h wt=%h, required 0 0", vld, wt);
    end
    // Level source held high while disabled.
    ttype = 0; en = 0;
    src[0] = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    tests++;
    if (vld !== 0 || wt !== 0) begin
      fails++;
      $display("[TB] FAIL level_disabled: got vld=%h wt=%h, required 0 0", vld, wt);
    end
    en[0] = 1'b1;
    tick();
    tests++;
    if (vld !== 32'h1) begin
      fails++;
      $display("[TB] FAIL level_enable_issue: got vld=%h, required 1", vld);
    end
    strobe_claim(0);
    src[0] = 1'b0;
    tick(); tick(); tick();
    strobe_complete(0);
    // A level that drops before enable rises leaves nothing behind.
    en[0] = 1'b0;
    src[0] = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    src[0] = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    en[0] = 1'b1;
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (vld !== 0 || wt !== 0) bad = 1;
    end
    tests++;
    if (bad) begin
      fails++;
      $display("[TB] FAIL level_no_latch: got vld=%h wt=%h, required 0 0 throughout", vld, wt);
    end
  endtask

  task automatic test_same_cycle();
    bit got;
    do_reset();
    en = 32'h210;
    src = 32'h210;
    got = 0;
    for (int k = 0; k < 10 && !got; k++) begin
      tick();
      if (wt === 32'h210) got = 1;
    end
    tests++;
    if (!got) begin
      fails++;
      $display("[TB] FAIL pair_issue: got wt=%h, required 210", wt);
    end
    src = 0;
    tick(); tick(); tick();
    strobe_claim(9);
    claim = 1'b1; cid = 5'd4; comp = 1'b1; coid = 5'd9;
    tick();
    claim = 1'b0; comp = 1'b0;
    tests++;
    if (srv !== 32'h10 || wt !== 32'h0) begin
      fails++;
      $display("[TB] FAIL claim_and_complete: got srv=%h wt=%h, required srv=10 wt=0", srv, wt);
    end
    strobe_claim(5);
    tests++;
    if (srv !== 32'h10 || wt !== 32'h0 || vld !== 0) begin
      fails++;
      $display("[TB] FAIL claim_idle_ignored: got srv=%h wt=%h vld=%h, required 10 0 0", srv, wt, vld);
    end
    strobe_complete(4);
  endtask

  task automatic test_reset_mid();
    bit bad;
    do_reset();
    ttype = 32'h6; en = 32'h6;
    tick();
    src = 32'h6;
    for (int k = 0; k < 4; k++) tick();
    src = 0;
    tick(); tick();
    strobe_claim(1);
    strobe_claim(2);
    pulse(32'h6);
    pulse(32'h6);
    tick(); tick();
    tests++;
    if (srv !== 32'h6) begin
      fails++;
      $display("[TB] FAIL mid_pre_reset: got srv=%h, required 6", srv);
    end
    rstn = 1'b0;
    #1;
    tests++;
    if (vld !== 0 || srv !== 0 || wt !== 0) begin
      fails++;
      $display("[TB] FAIL mid_reset_clear: got vld=%h srv=%h wt=%h, required all 0", vld, srv, wt);
    end
    tick(); tick();
    rstn = 1'b1;
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (vld !== 0 || wt !== 0 || srv !== 0) bad = 1;
    end
    tests++;
    if (bad) begin
      fails++;
      $display("[TB] FAIL mid_after_release: got vld=%h wt=%h srv=%h, required all 0", vld, wt, srv);
    end
  endtask

  task automatic test_random();
    logic [31:0] e_srv, e_wt;
    int          start;
    do_reset();
    ttype = $urandom;
    for (int c = 0; c < 400; c++) begin
      src = $urandom & $urandom;
      en  = $urandom | $urandom;
      if ($urandom_range(0, 19) == 0) ttype[$urandom_range(0, 31)] ^= 1'b1;
      claim = 1'b0; comp = 1'b0;
      start = $urandom_range(0, 31);
      for (int k = 0; k < 32; k++) begin
        if (!claim && m_st[(start + k) % 32] == 1 && $urandom_range(0, 1) == 1) begin
          claim = 1'b1; cid = 5'((start + k) % 32);
        end
        if (!comp && m_st[(start + k) % 32] == 2 && $urandom_range(0, 1) == 1) begin
          comp = 1'b1; coid = 5'((start + k) % 32);
        end
      end
      if (!claim && $urandom_range(0, 3) == 0) begin
        claim = 1'b1; cid = 5'($urandom_range(0, 31));
      end
      tick();
      e_srv = 0; e_wt = 0;
      for (int i = 0; i < 32; i++) begin
        e_srv[i] = (m_st[i] == 2);
        e_wt[i]  = (m_st[i] == 1);
      end
      tests++;
      if (vld !== m_vld) begin
        fails++;
        $display("[TB] FAIL rand_vld c=%0d: got %h, required %h", c, vld, m_vld);
      end
      tests++;
      if (srv !== e_srv) begin
        fails++;
        $display("[TB] FAIL rand_srv c=%0d: got %h, required %h", c, srv, e_srv);
      end
      tests++;
      if (wt !== e_wt) begin
        fails++;
        $display("[TB] FAIL rand_wait c=%0d: got %h, required %h", c, wt, e_wt);
      end
    end
    idle_inputs();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    idle_inputs();
    rstn = 1'b0;
    #1;
    test_reset();
    test_level();
    test_edge_saturate();
    test_enable();
    test_same_cycle();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
